// File: rtl/moving_sum_decoder.sv
// Moving-sum decoder: recovers X from the running-sum stream S with X[n] = S[n] - S[n-1] + X[n-TAPS].
// Optional sample counter enabled by defining MSUM_DEC_CNT_EN.
module moving_sum_decoder #(
   parameter int N    = 4,
   parameter int TAPS = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [N-1:0] S,
   output logic [N-1:0] X,
`ifdef MSUM_DEC_CNT_EN
   output logic [15:0]  sample_cnt,
`endif
   output logic         valid
);

   logic [N-1:0] s_prev_q;
   logic [N-1:0] x_hist_q [TAPS];
   logic [N-1:0] x_q;
   logic         valid_q;
   logic [N-1:0] d;

   // N-bit arithmetic wraps naturally, which is exactly the modular inverse of the accumulator.
   always_comb begin
      d = S - s_prev_q + x_hist_q[TAPS-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_prev_q <= '0;
         x_q      <= '0;
         valid_q  <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            x_hist_q[k] <= '0;
         end
      end else begin
         valid_q <= load;
         if (load) begin
            s_prev_q    <= S;
            x_q         <= d;
            x_hist_q[0] <= d;
            for (int k = 1; k < TAPS; k++) begin
               x_hist_q[k] <= x_hist_q[k-1];
            end
         end
      end
   end

`ifdef MSUM_DEC_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign sample_cnt = cnt_q;
`endif

   assign X     = x_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Scoreboard bench for moving_sum_decoder: directed cases plus random loopback through an accumulator model.
module tb_moving_sum_decoder;

   localparam int N    = 4;
   localparam int TAPS = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         load = 1'b0;
   logic [N-1:0] S = '0;
   logic [N-1:0] X;
   logic         valid;
`ifdef MSUM_DEC_CNT_EN
   logic [15:0]  sample_cnt;
`endif

   int checks = 0;
   int fails  = 0;
   int loads_issued = 0;
   int valids_seen  = 0;

   logic [N-1:0] exp_q [$];
   int           win [$];

   moving_sum_decoder #(.N(N), .TAPS(TAPS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .S          (S),
      .X          (X),
`ifdef MSUM_DEC_CNT_EN
      .sample_cnt (sample_cnt),
`endif
      .valid      (valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end else begin
         $display("ok   %s: value=%0d", name, act);
      end
   endtask

   // Monitor: every valid cycle pops one expected sample.
   initial begin
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            valids_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_valid: actual X=%0d required=no output", X);
            end else begin
               logic [N-1:0] e;
               e = exp_q.pop_front();
               if (X !== e) begin
                  fails++;
                  $display("FAIL decode: actual X=%0d required X=%0d", X, e);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      load    = 1'b0;
      S       = '0;
      #1;
      check("reset_X_immediate", int'(X), 0);
      check("reset_valid_immediate", int'(valid), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      win.delete();
      for (int i = 0; i < TAPS; i++) win.push_back(0);
   endtask

   task automatic load_s(input int s, input int x_exp);
      @(posedge clk);
      #1;
      load = 1'b1;
      S    = N'(s);
      exp_q.push_back(N'(x_exp));
      loads_issued++;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Accumulator model: S is the mod-2^N sum of the last TAPS source samples.
   task automatic send_x(input int x);
      int sum;
      void'(win.pop_back());
      win.push_front(x);
      sum = 0;
      foreach (win[i]) sum += win[i];
      load_s(sum % (1 << N), x);
   endtask

   initial begin
      int s1 [5] = '{1, 3, 6, 10, 14};
      int x1 [5] = '{1, 2, 3, 4, 5};
      int s2 [5] = '{15, 14, 13, 12, 12};

      repeat (2) @(negedge clk);
      check("initial_reset_X", int'(X), 0);
      check("initial_reset_valid", int'(valid), 0);
`ifdef MSUM_DEC_CNT_EN
      check("initial_reset_cnt", int'(sample_cnt), 0);
`endif
      reset_n = 1'b1;

      // Ramp
      do_reset();
      for (int i = 0; i < 5; i++) load_s(s1[i], x1[i]);
      idle_cycle();
      idle_cycle();
      #1;
      check("ramp_valid_low_after", int'(valid), 0);
      check("ramp_X_hold", int'(X), 5);

      // Wrap through modular subtraction
      do_reset();
      for (int i = 0; i < 5; i++) load_s(s2[i], 15);
      idle_cycle();

      // S=0 right after reset
      do_reset();
      load_s(0, 0);
      idle_cycle();

      // Gapped loads
      do_reset();
      load_s(1, 1);
      idle_cycle();
      idle_cycle();
      #1;
      check("gap1_valid", int'(valid), 0);
      check("gap1_X_hold", int'(X), 1);
      idle_cycle();
      #1;
      check("gap2_valid", int'(valid), 0);
      check("gap2_X_hold", int'(X), 1);
      load_s(3, 2);
      idle_cycle();

      // Reset mid-stream while valid is high
      do_reset();
      load_s(1, 1);
      load_s(3, 2);
      idle_cycle();
      @(negedge clk);
      #2;
      check("pre_reset_valid", int'(valid), 1);
      reset_n = 1'b0;
      #1;
      check("midreset_X", int'(X), 0);
      check("midreset_valid", int'(valid), 0);
      repeat (2) @(negedge clk);
      check("midreset_hold_valid", int'(valid), 0);
      reset_n = 1'b1;
      load_s(5, 5);
      idle_cycle();

      // Random loopback with random gaps
      do_reset();
      for (int i = 0; i < 200; i++) begin
         send_x(int'($urandom_range((1 << N) - 1, 0)));
         if ($urandom_range(3, 0) == 0) idle_cycle();
      end
      idle_cycle();

`ifdef MSUM_DEC_CNT_EN
      do_reset();
      check("cnt_after_reset", int'(sample_cnt), 0);
      for (int i = 0; i < 65537; i++) load_s(0, 0);
      idle_cycle();
      #1;
      check("cnt_after_wrap", int'(sample_cnt), 1);
`endif

      repeat (4) @(negedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      check("valid_count", valids_seen, loads_issued);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
